// File: rtl/mem_arbiter.sv
// Arbiter between a scalar and a vector requester sharing one single-ported
// memory. One transaction runs at a time, an IDLE cycle separates
// transactions, and ties alternate between the two requesters.
module mem_arbiter #(
  parameter int DATA_W     = 64,
  parameter int ADDR_BITS  = 6,
  parameter int VECT_BEATS = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  // scalar requester
  input  logic                 s_req_i,
  input  logic                 s_we_i,
  input  logic [ADDR_BITS-1:0] s_addr_i,
  input  logic [DATA_W-1:0]    s_wd_i,
  output logic                 s_gnt_o,
  output logic                 s_rvalid_o,
  output logic [DATA_W-1:0]    s_rd_o,
  // vector requester
  input  logic                 v_req_i,
  input  logic                 v_we_i,
  input  logic [ADDR_BITS-1:0] v_addr_i,
  input  logic [DATA_W-1:0]    v_wd_i,
  output logic                 v_gnt_o,
  output logic [3:0]           v_beat_o,
  output logic                 v_rvalid_o,
  output logic [DATA_W-1:0]    v_rd_o,
  output logic                 v_done_o,
  // memory port
  output logic                 mem_we_o,
  output logic [ADDR_BITS-1:0] mem_a_o,
  output logic [DATA_W-1:0]    mem_wd_o,
  input  logic [DATA_W-1:0]    mem_rd_i,
  // pipeline stall
  output logic                 stall_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCALAR = 2'd1,
    VECTOR = 2'd2
  } state_e;

  localparam logic [3:0] LAST_BEAT = 4'(VECT_BEATS - 1);

  state_e                 state_q, state_d;
  logic [3:0]             beat_q, beat_d;
  logic                   last_vec_q, last_vec_d;  // 1: vector won the last grant
  logic                   start_s, start_v;

  logic                   s_we_q;
  logic [ADDR_BITS-1:0]   s_addr_q;
  logic [DATA_W-1:0]      s_wd_q;
  logic                   v_we_q;
  logic [ADDR_BITS-1:0]   v_addr_q;

  logic                   s_rv_q, v_rv_q;

  // State, beat counter and round-robin memory registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      last_vec_q <= 1'b1;  // scalar wins the first tie
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      last_vec_q <= last_vec_d;
    end
  end

  // Next-state logic: arbitration in IDLE, fixed-length active states.
  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    last_vec_d = last_vec_q;
    start_s    = 1'b0;
    start_v    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (s_req_i && v_req_i) begin
          start_s = last_vec_q;
          start_v = !last_vec_q;
        end else begin
          start_s = s_req_i;
          start_v = v_req_i;
        end
        if (start_s) begin
          state_d    = SCALAR;
          last_vec_d = 1'b0;
        end else if (start_v) begin
          state_d    = VECTOR;
          last_vec_d = 1'b1;
          beat_d     = '0;
        end
      end
      SCALAR: state_d = IDLE;
      VECTOR: begin
        if (beat_q == LAST_BEAT) begin
          state_d = IDLE;
          beat_d  = '0;
        end else begin
          beat_d = beat_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Capture request fields at the grant edge; later input changes are ignored.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      s_we_q   <= 1'b0;
      s_addr_q <= '0;
      s_wd_q   <= '0;
      v_we_q   <= 1'b0;
      v_addr_q <= '0;
    end else begin
      if (start_s) begin
        s_we_q   <= s_we_i;
        s_addr_q <= s_addr_i;
        s_wd_q   <= s_wd_i;
      end
      if (start_v) begin
        v_we_q   <= v_we_i;
        v_addr_q <= v_addr_i;
      end
    end
  end

  // Read-valid flags trail each read cycle by one clock, matching memory latency.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      s_rv_q <= 1'b0;
      v_rv_q <= 1'b0;
    end else begin
      s_rv_q <= (state_q == SCALAR) && !s_we_q;
      v_rv_q <= (state_q == VECTOR) && !v_we_q;
    end
  end

  // Memory port and handshake outputs; everything is quiet outside active states.
  always_comb begin
    mem_we_o = 1'b0;
    mem_a_o  = '0;
    mem_wd_o = '0;
    s_gnt_o  = 1'b0;
    v_gnt_o  = 1'b0;
    v_done_o = 1'b0;
    v_beat_o = '0;
    unique case (state_q)
      SCALAR: begin
        mem_we_o = s_we_q;
        mem_a_o  = s_addr_q;
        mem_wd_o = s_wd_q;
        s_gnt_o  = 1'b1;
      end
      VECTOR: begin
        mem_we_o = v_we_q;
        mem_a_o  = v_addr_q + ADDR_BITS'(beat_q);  // wraps at the top line
        mem_wd_o = v_wd_i;                         // per-beat data passes straight through
        v_gnt_o  = (beat_q == '0);
        v_done_o = (beat_q == LAST_BEAT);
        v_beat_o = beat_q;
      end
      default: ;
    endcase
  end

  // Stall covers active transactions and pending requests; reset silences it.
  always_comb begin
    stall_o    = rst_i & ((state_q != IDLE) | s_req_i | v_req_i);
    s_rvalid_o = s_rv_q;
    v_rvalid_o = v_rv_q;
    s_rd_o     = s_rv_q ? mem_rd_i : '0;
    v_rd_o     = v_rv_q ? mem_rd_i : '0;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, hand-written corner sequences
// and a randomized run checked against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int DW = 64;
  localparam int AW = 6;
  localparam int VB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          s_req, s_we, v_req, v_we;
  logic [AW-1:0] s_addr, v_addr;
  logic [DW-1:0] s_wd, v_wd;
  logic          s_gnt, s_rvalid, v_gnt, v_rvalid, v_done, mem_we, stall;
  logic [DW-1:0] s_rd, v_rd, mem_wd, mem_rd;
  logic [3:0]    v_beat;
  logic [AW-1:0] mem_a;

  mem_arbiter #(.DATA_W(DW), .ADDR_BITS(AW), .VECT_BEATS(VB)) dut (
    .clk_i(clk), .rst_i(rst_n),
    .s_req_i(s_req), .s_we_i(s_we), .s_addr_i(s_addr), .s_wd_i(s_wd),
    .s_gnt_o(s_gnt), .s_rvalid_o(s_rvalid), .s_rd_o(s_rd),
    .v_req_i(v_req), .v_we_i(v_we), .v_addr_i(v_addr), .v_wd_i(v_wd),
    .v_gnt_o(v_gnt), .v_beat_o(v_beat), .v_rvalid_o(v_rvalid), .v_rd_o(v_rd),
    .v_done_o(v_done),
    .mem_we_o(mem_we), .mem_a_o(mem_a), .mem_wd_o(mem_wd), .mem_rd_i(mem_rd),
    .stall_o(stall)
  );

  // Behavioural single-ported memory with one-cycle read latency.
  logic [DW-1:0] tb_mem [64];
  always @(posedge clk) begin
    if (mem_we) tb_mem[mem_a] <= mem_wd;
    mem_rd <= tb_mem[mem_a];
  end

  typedef struct packed {
    logic          s_gnt;
    logic          s_rv;
    logic [DW-1:0] s_rd;
    logic          v_gnt;
    logic [3:0]    v_beat;
    logic          v_rv;
    logic [DW-1:0] v_rd;
    logic          v_done;
    logic          m_we;
    logic [AW-1:0] m_a;
    logic [DW-1:0] m_wd;
    logic          stall;
  } outs_t;

  typedef struct {
    logic          s_req, s_we;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wd;
    logic          v_req, v_we;
    logic [AW-1:0] v_addr;
    logic [DW-1:0] v_wd;
    bit            in_vec;
    outs_t         exp;
  } vec_t;

  typedef struct {
    bit            is_vec;
    int            beat;
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] wd;
  } op_t;

  int total = 0;
  int bad   = 0;
  vec_t tbl[$];

  function automatic outs_t o(logic sg, logic srv, logic [DW-1:0] srd,
                              logic vg, logic [3:0] vb, logic vrv, logic [DW-1:0] vrd,
                              logic vd, logic we, logic [AW-1:0] a, logic [DW-1:0] wd,
                              logic st);
    outs_t r;
    r.s_gnt = sg; r.s_rv = srv; r.s_rd = srd;
    r.v_gnt = vg; r.v_beat = vb; r.v_rv = vrv; r.v_rd = vrd; r.v_done = vd;
    r.m_we = we; r.m_a = a; r.m_wd = wd; r.stall = st;
    return r;
  endfunction

  function automatic void add(logic sr, logic sw, logic [AW-1:0] sa, logic [DW-1:0] sd,
                              logic vr, logic vw, logic [AW-1:0] va, logic [DW-1:0] vd,
                              bit iv, outs_t e);
    vec_t t;
    t.s_req = sr; t.s_we = sw; t.s_addr = sa; t.s_wd = sd;
    t.v_req = vr; t.v_we = vw; t.v_addr = va; t.v_wd = vd;
    t.in_vec = iv; t.exp = e;
    tbl.push_back(t);
  endfunction

  function automatic outs_t get_act();
    outs_t r;
    r.s_gnt = s_gnt; r.s_rv = s_rvalid; r.s_rd = s_rd;
    r.v_gnt = v_gnt; r.v_beat = v_beat; r.v_rv = v_rvalid; r.v_rd = v_rd; r.v_done = v_done;
    r.m_we = mem_we; r.m_a = mem_a; r.m_wd = mem_wd; r.stall = stall;
    return r;
  endfunction

  // Read data is only meaningful with its valid; beat index only inside a vector.
  task automatic chk(string name, outs_t e, bit in_vec);
    outs_t a;
    a = get_act();
    if (!e.s_rv) begin a.s_rd = '0; e.s_rd = '0; end
    if (!e.v_rv) begin a.v_rd = '0; e.v_rd = '0; end
    if (!in_vec) begin a.v_beat = '0; e.v_beat = '0; end
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, a, e);
    end
  endtask

  task automatic chk_v(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    s_req = 0; s_we = 0; s_addr = '0; s_wd = '0;
    v_req = 0; v_we = 0; v_addr = '0; v_wd = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  // Transaction-level reference model state.
  op_t           plan[$];
  bit            last_vec;
  bit            p_srv, p_vrv;
  logic [DW-1:0] p_srd, p_vrd;
  logic [DW-1:0] ref_mem [64];

  // One cycle of the model: replay a planned memory cycle, or arbitrate in IDLE.
  task automatic model_cycle(output outs_t e_out);
    outs_t e;
    op_t   p;
    bit    inv, take_s, take_v;
    e = '0; inv = 0;
    e.s_rv = p_srv; e.s_rd = p_srd; e.v_rv = p_vrv; e.v_rd = p_vrd;
    p_srv = 0; p_vrv = 0;
    if (plan.size() > 0) begin
      p = plan.pop_front();
      e.stall = 1; e.m_a = p.addr; e.m_we = p.we;
      if (!p.is_vec) begin
        e.s_gnt = 1; e.m_wd = p.wd;
      end else begin
        inv = 1;
        e.v_gnt = (p.beat == 0); e.v_done = (p.beat == VB - 1);
        e.v_beat = 4'(p.beat); e.m_wd = v_wd;
      end
      chk("rand", e, inv);
      if (p.we) ref_mem[p.addr] = e.m_wd;
      else if (p.is_vec) begin p_vrv = 1; p_vrd = ref_mem[p.addr]; end
      else begin p_srv = 1; p_srd = ref_mem[p.addr]; end
    end else begin
      e.stall = s_req | v_req;
      chk("rand", e, 0);
      take_s = s_req && (!v_req || last_vec);
      take_v = v_req && !take_s;
      if (take_s) begin
        plan.push_back('{is_vec: 0, beat: 0, addr: s_addr, we: s_we, wd: s_wd});
        last_vec = 0;
      end else if (take_v) begin
        for (int b = 0; b < VB; b++)
          plan.push_back('{is_vec: 1, beat: b,
                           addr: AW'((int'(v_addr) + b) % 64), we: v_we, wd: '0});
        last_vec = 1;
      end
    end
    e_out = e;
  endtask

  initial begin
    logic [1:0] exp_g [9];
    outs_t      e;
    bit         s_pend, v_pend, busy;

    for (int i = 0; i < 64; i++) tb_mem[i] <= 64'h1000 + 64'(i);

    // Reset asserted with requests pending: everything stays silent.
    rst_n = 1'b0;
    idle_inputs();
    s_req = 1; v_req = 1;
    #1 chk("reset_state", o(0,0,0, 0,0,0,0,0, 0,0,0, 0), 1);
    repeat (2) tick();
    chk("reset_hold", o(0,0,0, 0,0,0,0,0, 0,0,0, 0), 1);
    idle_inputs();
    rst_n = 1'b1;

    // Vector write base 10 aborted by reset during beat 2.
    v_req = 1; v_we = 1; v_addr = 10; v_wd = 64'hAA;
    tick();
    v_req = 0; v_wd = 64'hAA;
    tick();
    v_wd = 64'hBB;
    tick();
    v_wd = 64'hCC;
    #1 chk("abort_beat2", o(0,0,0, 0,4'd2,0,0,0, 1,12,64'hCC, 1), 1);
    s_req = 1; v_req = 1;
    rst_n = 1'b0;
    #1 chk("abort_async", o(0,0,0, 0,0,0,0,0, 0,0,0, 0), 1);
    repeat (2) tick();
    idle_inputs();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_after", o(0,0,0, 0,0,0,0,0, 0,0,0, 0), 1);
    end
    chk_v("abort_line10", tb_mem[10], 64'hAA);
    chk_v("abort_line11", tb_mem[11], 64'hBB);
    chk_v("abort_line12", tb_mem[12], 64'h100C);
    chk_v("abort_line13", tb_mem[13], 64'h100D);

    // Cycle-by-cycle table: scalar write/read, wrapping vector read, vector write.
    add(1,1,5,64'hA5, 0,0,0,0, 0, o(0,0,0, 0,0,0,0,0, 0,0,0, 1));
    add(1,1,5,64'hA5, 0,0,0,0, 0, o(1,0,0, 0,0,0,0,0, 1,5,64'hA5, 1));
    add(1,0,5,0,      0,0,0,0, 0, o(0,0,0, 0,0,0,0,0, 0,0,0, 1));
    add(1,0,5,0,      0,0,0,0, 0, o(1,0,0, 0,0,0,0,0, 0,5,0, 1));
    add(0,0,0,0,      0,0,0,0, 0, o(0,1,64'hA5, 0,0,0,0,0, 0,0,0, 0));
    add(0,0,0,0,      1,0,62,0, 0, o(0,0,0, 0,0,0,0,0, 0,0,0, 1));
    add(0,0,0,0,      1,0,62,0, 1, o(0,0,0, 1,0,0,0,0, 0,62,0, 1));
    add(0,0,0,0,      0,0,0,0, 1, o(0,0,0, 0,1,1,64'h103E,0, 0,63,0, 1));
    add(0,0,0,0,      0,0,0,0, 1, o(0,0,0, 0,2,1,64'h103F,0, 0,0,0, 1));
    add(0,0,0,0,      0,0,0,0, 1, o(0,0,0, 0,3,1,64'h1000,1, 0,1,0, 1));
    add(0,0,0,0,      0,0,0,0, 0, o(0,0,0, 0,0,1,64'h1001,0, 0,0,0, 0));
    add(0,0,0,0,      1,1,10,64'h11, 0, o(0,0,0, 0,0,0,0,0, 0,0,0, 1));
    add(0,0,0,0,      1,1,10,64'h11, 1, o(0,0,0, 1,0,0,0,0, 1,10,64'h11, 1));
    add(0,0,0,0,      0,0,0,64'h22, 1, o(0,0,0, 0,1,0,0,0, 1,11,64'h22, 1));
    add(0,0,0,0,      0,0,0,64'h33, 1, o(0,0,0, 0,2,0,0,0, 1,12,64'h33, 1));
    add(0,0,0,0,      0,0,0,64'h44, 1, o(0,0,0, 0,3,0,0,1, 1,13,64'h44, 1));
    add(1,0,12,0,     0,0,0,0, 0, o(0,0,0, 0,0,0,0,0, 0,0,0, 1));
    add(1,0,12,0,     0,0,0,0, 0, o(1,0,0, 0,0,0,0,0, 0,12,0, 1));
    add(0,0,0,0,      0,0,0,0, 0, o(0,1,64'h33, 0,0,0,0,0, 0,0,0, 0));

    do_reset();
    foreach (tbl[i]) begin
      s_req = tbl[i].s_req; s_we = tbl[i].s_we; s_addr = tbl[i].s_addr; s_wd = tbl[i].s_wd;
      v_req = tbl[i].v_req; v_we = tbl[i].v_we; v_addr = tbl[i].v_addr; v_wd = tbl[i].v_wd;
      #1 chk($sformatf("table_%0d", i), tbl[i].exp, tbl[i].in_vec);
      tick();
    end
    chk_v("table_line13", tb_mem[13], 64'h44);

    // Tie after reset, both held: scalar, bubble, vector, bubble, scalar.
    exp_g = '{2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10};
    do_reset();
    s_req = 1; s_we = 0; s_addr = 3;
    v_req = 1; v_we = 0; v_addr = 20;
    for (int c = 0; c < 9; c++) begin
      #1 chk_v($sformatf("tie_gnt_c%0d", c), {62'd0, s_gnt, v_gnt}, {62'd0, exp_g[c]});
      tick();
    end

    // Request inputs churn during a vector read; the transaction is unaffected.
    do_reset();
    v_req = 1; v_we = 0; v_addr = 30;
    tick();
    for (int b = 0; b < VB; b++) begin
      v_req = (b < VB - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      v_we = 1; v_addr = AW'($urandom);
      s_req = (b >= 1); s_we = 0; s_addr = 7;
      #1 chk_v($sformatf("churn_beat%0d", b), {57'd0, mem_we, mem_a}, {57'd0, 1'b0, 6'(30 + b)});
      tick();
    end
    v_req = 0;
    #1 chk_v("churn_bubble", {62'd0, s_gnt, stall}, {62'd0, 2'b01});
    tick();
    chk_v("churn_scalar", {57'd0, s_gnt, mem_a}, {57'd0, 1'b1, 6'd7});
    s_req = 0;

    // Randomized traffic against the reference model.
    do_reset();
    for (int i = 0; i < 64; i++) ref_mem[i] = tb_mem[i];
    plan.delete();
    last_vec = 1; p_srv = 0; p_vrv = 0; p_srd = '0; p_vrd = '0;
    s_pend = 0; v_pend = 0;
    for (int c = 0; c < 1500; c++) begin
      busy = (plan.size() != 0);
      if (!s_pend) begin
        s_we = 1'($urandom); s_addr = AW'($urandom); s_wd = {$urandom, $urandom};
        if (!busy && $urandom_range(0, 1) == 1) begin
          s_req = 1; s_pend = 1;
        end else begin
          s_req = busy ? 1'($urandom) : 1'b0;
        end
      end
      if (!v_pend) begin
        v_we = 1'($urandom); v_addr = AW'($urandom);
        if (!busy && $urandom_range(0, 1) == 1) begin
          v_req = 1; v_pend = 1;
        end else begin
          v_req = busy ? 1'($urandom) : 1'b0;
        end
      end
      v_wd = {$urandom, $urandom};
      #1 model_cycle(e);
      if (e.s_gnt) s_pend = 0;
      if (e.v_gnt) v_pend = 0;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
